load_data_unit: RTL and testbench
=================================

// Module: load_data_unit
// PURPOSE
//  Memory-stage load engine for the 5-stage MIPS pipeline; the read-side
//  counterpart of the execute-stage store byte-enable/data replicator.
//  Issues word-aligned reads on the data SRAM-like bus and stalls the pipe
//  until data returns. Extracts the addressed byte/half and sign/zero-extends
//  it; flags misaligned loads as AdEL.
// PARAMETERS
//  OP_W   8   width of the ALU-control opcode bus (encodings from defines.vh)
// PORTS
//  clk           in   1     clock, rising edge
//  resetn        in   1     async reset, active low
//  alucontrolM   in   OP_W  op of the instruction in MEM (`EXE_LW/LB/LBU/LH/LHU_OP)
//  addrM         in   32    effective address (aluout)
//  load_validM   in   1     MEM holds a valid, unflushed instruction
//  flushM        in   1     exception/flush: abandon current load
//  data_req      out  1     bus request
//  data_addr     out  32    {addr[31:2],2'b00}
//  data_size     out  2     0=byte, 1=half, 2=word
//  data_addr_ok  in   1     request accepted this cycle
//  data_ok       in   1     rdata valid this cycle
//  data_rdata    in   32    read word
//  load_result   out  32    extended load value
//  result_valid  out  1     1-cycle pulse: load_result valid for writeback
//  stall_req     out  1     hold IF..MEM this cycle
//  adel          out  1     misaligned-load exception (combinational)
//  badvaddr      out  32    faulting address (= addrM when adel)
// BEHAVIOUR
//  Reset: state=IDLE, data_req=0, result_valid=0, load_result=0, latched op/addr=0.
//  is_load = op in {LW,LB,LBU,LH,LHU}. Misaligned: LW addr[1:0]!=0;
//   LH/LHU addr[0]!=0. adel = load_validM & is_load & misaligned; no request.
//  FSM IDLE -> REQ -> WAIT -> DONE -> IDLE; flush path REQ/WAIT -> DRAIN.
//  IDLE: on load_validM & is_load & !misaligned & !flushM: latch op and
//   addr[1:0], go REQ. stall_req=1 that same cycle.
//  REQ: data_req=1, addr/size from latched values, held stable until
//   data_addr_ok. On addr_ok go WAIT, or DONE if data_ok in the same cycle.
//  WAIT: data_req=0. On data_ok: register extracted value, go DONE.
//  DONE: result_valid=1, stall_req=0 for exactly 1 cycle; then IDLE.
//  stall_req=1 in REQ, WAIT and DRAIN, and in IDLE on a start.
//  Extraction by latched addr[1:0]:
//   LB/LBU lanes: 00->[7:0], 01->[15:8], 10->[23:16], 11->[31:24];
//   LB sign-extends bit 7 of the lane, LBU zero-extends.
//   LH/LHU: 00->[15:0], 10->[31:16]; LH sign-, LHU zero-extends. LW: word.
//  Flush: IDLE -> no request issued.
//   REQ -> keep req until addr_ok (a request is never withdrawn), then DRAIN.
//   WAIT -> DRAIN. DRAIN: wait data_ok, discard data, return IDLE.
//   No result_valid for flushed loads. stall_req=1 in DRAIN.
//   If addr_ok and data_ok both arrive in the flushing cycle, go straight to IDLE.
//  data_ok outside REQ/WAIT/DRAIN is ignored. Only one load in flight at a time.
//  Async reset mid-transaction: return to IDLE immediately; the bus is reset
//   by the same resetn.
// TESTING
//  LB addr=0x103, rdata=0x80AA55CC, addr_ok+data_ok 1 cycle later ->
//   data_addr=0x100, size=0, load_result=0xFFFFFF80, one result_valid pulse.
//  LHU addr=0x102, rdata=0x9ABC1234 -> 0x00009ABC; LH same -> 0xFFFF9ABC.
//  LW addr=0x206 -> adel=1, badvaddr=0x206, data_req stays 0, stall_req=0.
//  addr_ok delayed 3 cycles, data_ok 4 later -> req/addr held stable,
//   stall_req=1 throughout, result_valid exactly once in DONE.
//  flushM in WAIT, data_ok 2 cycles later -> DRAIN, no result_valid; next
//   LW issues correctly with no stale data.
//  resetn low during WAIT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/load_data_unit_if.sv
// Data-side SRAM-like read bus between the load engine (master) and memory (slave).
// Requests are word-aligned; data_size qualifies the access width.
interface load_data_unit_if;
    logic        data_req;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic        data_addr_ok;
    logic        data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_addr, data_size,
        input  data_addr_ok, data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_addr, data_size,
        output data_addr_ok, data_ok, data_rdata
    );
endinterface

// File: rtl/load_data_unit.sv
// Memory-stage load engine: issues one word-aligned read at a time, stalls the pipe until
// data returns, then extracts and extends the addressed byte/half. Misaligned loads raise AdEL.
module load_data_unit #(
    parameter int unsigned     OP_W       = 8,
    parameter logic [OP_W-1:0] EXE_LB_OP  = OP_W'(8'hE0),
    parameter logic [OP_W-1:0] EXE_LH_OP  = OP_W'(8'hE1),
    parameter logic [OP_W-1:0] EXE_LW_OP  = OP_W'(8'hE3),
    parameter logic [OP_W-1:0] EXE_LBU_OP = OP_W'(8'hE4),
    parameter logic [OP_W-1:0] EXE_LHU_OP = OP_W'(8'hE5)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [OP_W-1:0]     alucontrolM,
    input  logic [31:0]         addrM,
    input  logic                load_validM,
    input  logic                flushM,
    load_data_unit_if.master    bus,
    output logic [31:0]         load_result,
    output logic                result_valid,
    output logic                stall_req,
    output logic                adel,
    output logic [31:0]         badvaddr
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic [31:0]       addr_q;
    logic [31:0]       load_result_q;
    logic              flushed_q, flushed_d;
    logic              is_lb, is_lbu, is_lh, is_lhu, is_lw, is_load, misaligned, start;
    logic              latch, capture;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       extracted;

    assign is_lb   = (alucontrolM == EXE_LB_OP);
    assign is_lbu  = (alucontrolM == EXE_LBU_OP);
    assign is_lh   = (alucontrolM == EXE_LH_OP);
    assign is_lhu  = (alucontrolM == EXE_LHU_OP);
    assign is_lw   = (alucontrolM == EXE_LW_OP);
    assign is_load = is_lb | is_lbu | is_lh | is_lhu | is_lw;

    assign misaligned = (is_lw & (addrM[1:0] != 2'b00)) | ((is_lh | is_lhu) & addrM[0]);
    assign adel       = load_validM & is_load & misaligned;
    assign badvaddr   = addrM;
    assign start      = load_validM & is_load & ~misaligned & ~flushM;

    always_comb begin
        state_d      = state_q;
        flushed_d    = flushed_q;
        latch        = 1'b0;
        capture      = 1'b0;
        bus.data_req = 1'b0;
        stall_req    = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    latch     = 1'b1;
                    flushed_d = 1'b0;
                    stall_req = 1'b1;
                    state_d   = StReq;
                end
            end
            StReq: begin
                bus.data_req = 1'b1;
                stall_req    = 1'b1;
                if (flushM) flushed_d = 1'b1;
                // An accepted request can never be withdrawn; a flushed one is drained.
                if (bus.data_addr_ok) begin
                    if (flushed_q | flushM) begin
                        state_d = bus.data_ok ? StIdle : StDrain;
                    end else if (bus.data_ok) begin
                        capture = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                stall_req = 1'b1;
                if (flushM) begin
                    state_d = bus.data_ok ? StIdle : StDrain;
                end else if (bus.data_ok) begin
                    capture = 1'b1;
                    state_d = StDone;
                end
            end
            StDrain: begin
                stall_req = 1'b1;
                if (bus.data_ok) state_d = StIdle;
            end
            StDone: begin
                result_valid = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   lane_b = bus.data_rdata[7:0];
            2'b01:   lane_b = bus.data_rdata[15:8];
            2'b10:   lane_b = bus.data_rdata[23:16];
            default: lane_b = bus.data_rdata[31:24];
        endcase
        lane_h = addr_q[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
        if (op_q == EXE_LB_OP)       extracted = {{24{lane_b[7]}}, lane_b};
        else if (op_q == EXE_LBU_OP) extracted = {24'h0, lane_b};
        else if (op_q == EXE_LH_OP)  extracted = {{16{lane_h[15]}}, lane_h};
        else if (op_q == EXE_LHU_OP) extracted = {16'h0, lane_h};
        else                         extracted = bus.data_rdata;
    end

    always_comb begin
        if (op_q == EXE_LW_OP)                            bus.data_size = 2'd2;
        else if ((op_q == EXE_LH_OP) | (op_q == EXE_LHU_OP)) bus.data_size = 2'd1;
        else                                              bus.data_size = 2'd0;
    end

    assign bus.data_addr = {addr_q[31:2], 2'b00};
    assign load_result   = load_result_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= StIdle;
            op_q          <= '0;
            addr_q        <= '0;
            load_result_q <= '0;
            flushed_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            flushed_q <= flushed_d;
            if (latch) begin
                op_q   <= alucontrolM;
                addr_q <= addrM;
            end
            if (capture) load_result_q <= extracted;
        end
    end

endmodule

// File: tb/tb_load_data_unit.sv
// Directed self-checking bench for load_data_unit; the bench plays the memory side of the bus.
module tb_load_data_unit;

    localparam logic [7:0] LB = 8'hE0, LH = 8'hE1, LW = 8'hE3, LBU = 8'hE4, LHU = 8'hE5;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  alucontrolM;
    logic [31:0] addrM;
    logic        load_validM, flushM;
    logic [31:0] load_result, badvaddr;
    logic        result_valid, stall_req, adel;
    int          checks = 0;
    int          errors = 0;
    int          rv_count = 0;

    load_data_unit_if bus ();

    load_data_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .alucontrolM  (alucontrolM),
        .addrM        (addrM),
        .load_validM  (load_validM),
        .flushM       (flushM),
        .bus          (bus),
        .load_result  (load_result),
        .result_valid (result_valid),
        .stall_req    (stall_req),
        .adel         (adel),
        .badvaddr     (badvaddr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (result_valid === 1'b1) rv_count++;

    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [1:0]  size;
        logic [31:0] res;
    } vec_t;

    task automatic idle_bus();
        load_validM = 1'b0;
        flushM = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_ok = 1'b0;
        bus.data_rdata = 32'h0;
    endtask

    task automatic issue(input logic [7:0] op, input logic [31:0] addr);
        @(negedge clk);
        alucontrolM = op;
        addrM = addr;
        load_validM = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        alucontrolM = 8'h0;
        addrM = 32'h0;
        idle_bus();
        #1;
        checks++; if (bus.data_req !== 1'b0) begin errors++;
            $display("FAIL reset data_req: got %b want 0", bus.data_req); end
        checks++; if (result_valid !== 1'b0) begin errors++;
            $display("FAIL reset result_valid: got %b want 0", result_valid); end
        checks++; if (load_result !== 32'h0) begin errors++;
            $display("FAIL reset load_result: got %h want 0", load_result); end
        checks++; if (stall_req !== 1'b0) begin errors++;
            $display("FAIL reset stall_req: got %b want 0", stall_req); end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_extract();
        vec_t v[8];
        v[0] = '{op: LB,  addr: 32'h103, rdata: 32'h80AA55CC, size: 2'd0, res: 32'hFFFFFF80};
        v[1] = '{op: LBU, addr: 32'h101, rdata: 32'h80AA55CC, size: 2'd0, res: 32'h00000055};
        v[2] = '{op: LB,  addr: 32'h100, rdata: 32'h80AA55CC, size: 2'd0, res: 32'hFFFFFFCC};
        v[3] = '{op: LBU, addr: 32'h102, rdata: 32'h80AA55CC, size: 2'd0, res: 32'h000000AA};
        v[4] = '{op: LHU, addr: 32'h102, rdata: 32'h9ABC1234, size: 2'd1, res: 32'h00009ABC};
        v[5] = '{op: LH,  addr: 32'h102, rdata: 32'h9ABC1234, size: 2'd1, res: 32'hFFFF9ABC};
        v[6] = '{op: LH,  addr: 32'h100, rdata: 32'h9ABC1234, size: 2'd1, res: 32'h00001234};
        v[7] = '{op: LW,  addr: 32'h10C, rdata: 32'h9ABC1234, size: 2'd2, res: 32'h9ABC1234};
        for (int i = 0; i < 8; i++) begin
            issue(v[i].op, v[i].addr);
            checks++; if (stall_req !== 1'b1 || bus.data_req !== 1'b0) begin errors++;
                $display("FAIL extract[%0d] start: stall=%b req=%b want 1/0", i, stall_req,
                         bus.data_req); end
            @(negedge clk); #1;
            checks++; if (bus.data_req !== 1'b1) begin errors++;
                $display("FAIL extract[%0d] data_req: got %b want 1", i, bus.data_req); end
            checks++; if (bus.data_addr !== {v[i].addr[31:2], 2'b00}) begin errors++;
                $display("FAIL extract[%0d] data_addr: got %h want %h", i, bus.data_addr,
                         {v[i].addr[31:2], 2'b00}); end
            checks++; if (bus.data_size !== v[i].size) begin errors++;
                $display("FAIL extract[%0d] data_size: got %0d want %0d", i, bus.data_size,
                         v[i].size); end
            bus.data_addr_ok = 1'b1;
            bus.data_ok = 1'b1;
            bus.data_rdata = v[i].rdata;
            @(negedge clk);
            idle_bus();
            load_validM = 1'b1;
            #1;
            checks++; if (result_valid !== 1'b1 || stall_req !== 1'b0) begin errors++;
                $display("FAIL extract[%0d] done: valid=%b stall=%b want 1/0", i, result_valid,
                         stall_req); end
            checks++; if (load_result !== v[i].res) begin errors++;
                $display("FAIL extract[%0d] load_result: got %h want %h", i, load_result,
                         v[i].res); end
            @(negedge clk);
            load_validM = 1'b0;
            #1;
            checks++; if (result_valid !== 1'b0) begin errors++;
                $display("FAIL extract[%0d] pulse width: result_valid still %b", i,
                         result_valid); end
        end
    endtask

    task automatic test_adel();
        logic [7:0]  ops[4];
        logic [31:0] addrs[4];
        ops = '{LW, LW, LH, LHU};
        addrs = '{32'h206, 32'h201, 32'h101, 32'h103};
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], addrs[i]);
            checks++; if (adel !== 1'b1 || badvaddr !== addrs[i]) begin errors++;
                $display("FAIL adel[%0d]: adel=%b badvaddr=%h want 1/%h", i, adel, badvaddr,
                         addrs[i]); end
            checks++; if (stall_req !== 1'b0 || bus.data_req !== 1'b0) begin errors++;
                $display("FAIL adel[%0d] no request: stall=%b req=%b want 0/0", i, stall_req,
                         bus.data_req); end
            @(negedge clk); #1;
            checks++; if (bus.data_req !== 1'b0) begin errors++;
                $display("FAIL adel[%0d] req after: got %b want 0", i, bus.data_req); end
            load_validM = 1'b0;
            #1;
            checks++; if (adel !== 1'b0) begin errors++;
                $display("FAIL adel[%0d] invalid slot: got %b want 0", i, adel); end
        end
    endtask

    task automatic test_delayed();
        int base;
        issue(LW, 32'h300);
        base = rv_count;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            addrM = 32'h3FC;
            #1;
            checks++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h300 ||
                          bus.data_size !== 2'd2 || stall_req !== 1'b1) begin errors++;
                $display("FAIL delayed req[%0d]: req=%b addr=%h size=%0d stall=%b want 1/300/2/1",
                         i, bus.data_req, bus.data_addr, bus.data_size, stall_req); end
        end
        bus.data_addr_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.data_addr_ok = 1'b0;
            #1;
            checks++; if (bus.data_req !== 1'b0 || stall_req !== 1'b1 || result_valid !== 1'b0)
                begin errors++;
                $display("FAIL delayed wait[%0d]: req=%b stall=%b valid=%b want 0/1/0", i,
                         bus.data_req, stall_req, result_valid); end
        end
        bus.data_ok = 1'b1;
        bus.data_rdata = 32'hCAFEF00D;
        @(negedge clk);
        idle_bus();
        load_validM = 1'b1;
        #1;
        checks++; if (result_valid !== 1'b1 || load_result !== 32'hCAFEF00D) begin errors++;
            $display("FAIL delayed done: valid=%b result=%h want 1/cafef00d", result_valid,
                     load_result); end
        @(negedge clk);
        load_validM = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (rv_count - base !== 1) begin errors++;
            $display("FAIL delayed pulses: got %0d want 1", rv_count - base); end
    endtask

    task automatic test_flush();
        int base;
        // Flush while waiting for data.
        issue(LW, 32'h400);
        base = rv_count;
        @(negedge clk); #1;
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        flushM = 1'b1;
        #1;
        checks++; if (stall_req !== 1'b1 || bus.data_req !== 1'b0) begin errors++;
            $display("FAIL flush wait: stall=%b req=%b want 1/0", stall_req, bus.data_req); end
        @(negedge clk);
        flushM = 1'b0;
        load_validM = 1'b0;
        #1;
        checks++; if (stall_req !== 1'b1 || bus.data_req !== 1'b0) begin errors++;
            $display("FAIL flush drain: stall=%b req=%b want 1/0", stall_req, bus.data_req); end
        @(negedge clk); #1;
        bus.data_ok = 1'b1;
        bus.data_rdata = 32'hDEADBEEF;
        @(negedge clk);
        idle_bus();
        #1;
        checks++; if (stall_req !== 1'b0 || load_result !== 32'hCAFEF00D) begin errors++;
            $display("FAIL flush discard: stall=%b result=%h want 0/cafef00d", stall_req,
                     load_result); end
        checks++; if (rv_count - base !== 0) begin errors++;
            $display("FAIL flush pulses: got %0d want 0", rv_count - base); end
        // Next load after the drain must see its own data.
        issue(LW, 32'h404);
        @(negedge clk); #1;
        checks++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h404) begin errors++;
            $display("FAIL post-flush req: req=%b addr=%h want 1/404", bus.data_req,
                     bus.data_addr); end
        bus.data_addr_ok = 1'b1;
        bus.data_ok = 1'b1;
        bus.data_rdata = 32'h11112222;
        @(negedge clk);
        idle_bus();
        #1;
        checks++; if (result_valid !== 1'b1 || load_result !== 32'h11112222) begin errors++;
            $display("FAIL post-flush result: valid=%b result=%h want 1/11112222", result_valid,
                     load_result); end
        // Flush while the request is still pending: request must stay up until accepted.
        issue(LBU, 32'h501);
        base = rv_count;
        @(negedge clk);
        flushM = 1'b1;
        #1;
        @(negedge clk);
        flushM = 1'b0;
        load_validM = 1'b0;
        #1;
        checks++; if (bus.data_req !== 1'b1 || stall_req !== 1'b1) begin errors++;
            $display("FAIL flush req held: req=%b stall=%b want 1/1", bus.data_req, stall_req); end
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        bus.data_addr_ok = 1'b0;
        #1;
        checks++; if (bus.data_req !== 1'b0 || stall_req !== 1'b1) begin errors++;
            $display("FAIL flush req drain: req=%b stall=%b want 0/1", bus.data_req, stall_req); end
        bus.data_ok = 1'b1;
        bus.data_rdata = 32'h77777777;
        @(negedge clk);
        idle_bus();
        #1;
        checks++; if (stall_req !== 1'b0 || load_result !== 32'h11112222 ||
                      rv_count - base !== 0) begin errors++;
            $display("FAIL flush req end: stall=%b result=%h pulses=%0d want 0/11112222/0",
                     stall_req, load_result, rv_count - base); end
        // Flush in the same cycle as a would-be start: nothing is issued.
        @(negedge clk);
        alucontrolM = LW;
        addrM = 32'h600;
        load_validM = 1'b1;
        flushM = 1'b1;
        #1;
        checks++; if (stall_req !== 1'b0) begin errors++;
            $display("FAIL flush start stall: got %b want 0", stall_req); end
        @(negedge clk);
        idle_bus();
        #1;
        checks++; if (bus.data_req !== 1'b0) begin errors++;
            $display("FAIL flush start req: got %b want 0", bus.data_req); end
        // Stray data_ok while idle is ignored.
        bus.data_ok = 1'b1;
        bus.data_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        idle_bus();
        #1;
        checks++; if (result_valid !== 1'b0 || load_result !== 32'h11112222) begin errors++;
            $display("FAIL idle data_ok: valid=%b result=%h want 0/11112222", result_valid,
                     load_result); end
    endtask

    task automatic test_async_reset();
        issue(LW, 32'h700);
        @(negedge clk); #1;
        bus.data_addr_ok = 1'b1;
        @(negedge clk);
        idle_bus();
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++;
            $display("FAIL areset pre wait: stall=%b want 1", stall_req); end
        #1;
        resetn = 1'b0;
        #1;
        checks++; if (stall_req !== 1'b0 || bus.data_req !== 1'b0 || result_valid !== 1'b0)
            begin errors++;
            $display("FAIL areset outputs: stall=%b req=%b valid=%b want 0/0/0", stall_req,
                     bus.data_req, result_valid); end
        checks++; if (load_result !== 32'h0) begin errors++;
            $display("FAIL areset load_result: got %h want 0", load_result); end
        @(negedge clk);
        resetn = 1'b1;
        // Recovery: a fresh load completes normally.
        issue(LHU, 32'h706);
        @(negedge clk); #1;
        checks++; if (bus.data_req !== 1'b1 || bus.data_addr !== 32'h704 ||
                      bus.data_size !== 2'd1) begin errors++;
            $display("FAIL areset recover req: req=%b addr=%h size=%0d want 1/704/1",
                     bus.data_req, bus.data_addr, bus.data_size); end
        bus.data_addr_ok = 1'b1;
        bus.data_ok = 1'b1;
        bus.data_rdata = 32'hBEEF0000;
        @(negedge clk);
        idle_bus();
        #1;
        checks++; if (result_valid !== 1'b1 || load_result !== 32'h0000BEEF) begin errors++;
            $display("FAIL areset recover result: valid=%b result=%h want 1/0000beef",
                     result_valid, load_result); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_extract();
        test_adel();
        test_delayed();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks,
                 errors);
        $fatal(1, "watchdog");
    end

endmodule
